mux_32x8_serial: RTL and testbench
==================================

Name: mux_32x8_serial

Overview:
- Upstream serializer for the 8x32 demux stage.
- Accepts 32-bit words through a valid/ready handshake and emits them as four consecutive bytes on the clk_4f domain.
- Drives a byte selector alongside each byte, so the downstream demux can reassemble the word.
- Holds one pending word in a skid register, so back-to-back words stream with no gap bytes.

Parameters:
MSB_FIRST  1  1: byte order [31:24],[23:16],[15:8],[7:0]; 0: byte order [7:0] first through [31:24] last

Ports:
clk_4f  input  1  byte-rate clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
data_in_32x8  input  32  word to serialize
valid_in_32x8  input  1  data_in_32x8 is valid this cycle
ready_out_32x8  output  1  block can accept a word this cycle
data_out_32x8  output  8  serialized byte
valid_out_32x8  output  1  data_out_32x8 and selector_clk_4f are valid
selector_clk_4f  output  2  index of the byte in flight within its word, 0..3

Behaviour:
- Interface (already decided): one clock, clk_4f. Reset is asynchronous and active-high, port name reset.
- Reset values: data_out_32x8=8'h00, valid_out_32x8=0, selector_clk_4f=2'b00, ready_out_32x8=1, FSM=IDLE, byte counter=0, pending register empty.
- Reset asserted mid-word: all state clears immediately, with no clock edge needed. The in-flight word and the pending word are dropped. No partial bytes appear after reset is released.
- Handshake:
  - Transfer occurs on a rising edge where valid_in_32x8 && ready_out_32x8.
  - ready_out_32x8 = !pend_valid, decoded from a register only. It has no combinational path from valid_in_32x8.
  - The upstream source holds data while valid_in_32x8=1 and ready_out_32x8=0.
- All outputs except ready_out_32x8 are registered.
- FSM IDLE:
  - valid_out_32x8=0, data_out_32x8=0.
  - On a transfer, the word loads into the shift register and the FSM moves to SHIFT with cnt=0.
  - In the same edge, outputs become byte 0, selector_clk_4f=0, valid_out_32x8=1.
  - Latency: first byte is visible in the cycle immediately after the accepting edge.
- FSM SHIFT, cnt<3:
  - Each edge advances cnt and drives byte cnt+1 with selector_clk_4f=cnt+1.
  - A transfer in this state stores the word in the pending register and sets pend_valid.
- FSM SHIFT, edge with cnt==3 (last byte currently on the outputs):
  - If pend_valid: load the pending word, clear pend_valid, output its byte 0, set cnt=0.
  - Else if a transfer occurs on this edge: bypass the input word straight into the shift register, output its byte 0, set cnt=0.
  - Else: go to IDLE, valid_out_32x8=0, data_out_32x8=0, selector_clk_4f=0.
- Simultaneous transfer and pending-drain cannot occur, because ready=0 whenever pend_valid=1.
- Throughput: sustained 1 word per 4 cycles with valid_out_32x8 continuously high.
- Byte selection:
  - MSB_FIRST=1: byte k = data[31-8k -: 8].
  - MSB_FIRST=0: byte k = data[8k +: 8].
- selector_clk_4f always equals k, regardless of MSB_FIRST.
- Output data is 0 whenever valid_out_32x8=0. There are no X values after reset.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles, then release with valid_in=0 for 10 cycles -> valid_out=0, data_out=00, ready=1 throughout.
2. Single word, MSB_FIRST=1: send 32'hA1B2C3D4 once -> next 4 cycles data_out=A1,B2,C3,D4 with selector=0,1,2,3 and valid_out=1. Cycle 5 has valid_out=0.
3. Back-to-back words: valid_in held high with 32'h01020304 then 32'h05060708 -> 8 contiguous bytes 01..08, valid_out never drops. ready deasserts while the pending register is full and reasserts the cycle after the pending word loads.
4. Backpressure hold: present three words at once -> word 3 is held until ready=1 and is not lost or duplicated. Output order is words 1, 2, 3, 12 bytes total.
5. Reset mid-word: assert reset asynchronously between clock edges after byte 1 of 32'hDEADBEEF -> valid_out and data_out clear immediately. After release, no further DEADBEEF bytes appear.
6. MSB_FIRST=0 loopback: connect to the 8x32 demux, stream 32'h12345678 and 32'h9ABCDEF0 -> demux output reproduces both words in order, and selector matches the demux's expected byte index each cycle.

Source files
------------

// File: rtl/mux_32x8_serial.sv
// Serializes 32-bit words into four bytes on clk_4f, tagging each byte with its index.
// One pending word sits in a skid register so consecutive words stream without gap bytes.
module mux_32x8_serial #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [31:0] data_in_32x8,
  input  logic        valid_in_32x8,
  output logic        ready_out_32x8,
  output logic [7:0]  data_out_32x8,
  output logic        valid_out_32x8,
  output logic [1:0]  selector_clk_4f
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(3);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   shift_word;
  logic [WORD_W-1:0]   pend_word;
  logic                pend_valid;
  logic                xfer;

  // Byte k of a word in transmission order; the selector still reports k.
  function automatic logic [BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] w,
                                                input logic [CNT_W-1:0]  k);
    logic [CNT_W-1:0] idx;
    idx = MSB_FIRST ? CNT_W'(LAST_BYTE - k) : k;
    case (idx)
      2'd0:    byte_of = w[7:0];
      2'd1:    byte_of = w[15:8];
      2'd2:    byte_of = w[23:16];
      default: byte_of = w[31:24];
    endcase
  endfunction

  // Ready is a pure decode of the skid flag, never of valid_in.
  assign ready_out_32x8 = ~pend_valid;
  assign xfer           = valid_in_32x8 & ready_out_32x8;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      shift_word      <= '0;
      pend_word       <= '0;
      pend_valid      <= 1'b0;
      data_out_32x8   <= '0;
      valid_out_32x8  <= 1'b0;
      selector_clk_4f <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state           <= SHIFT;
            shift_word      <= data_in_32x8;
            cnt             <= '0;
            data_out_32x8   <= byte_of(data_in_32x8, CNT_W'(0));
            selector_clk_4f <= '0;
            valid_out_32x8  <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != LAST_BYTE) begin
            cnt             <= cnt + 2'd1;
            data_out_32x8   <= byte_of(shift_word, cnt + 2'd1);
            selector_clk_4f <= cnt + 2'd1;
            if (xfer) begin
              pend_word  <= data_in_32x8;
              pend_valid <= 1'b1;
            end
          end else if (pend_valid) begin
            // Drain the skid register into the shifter with no idle byte.
            shift_word      <= pend_word;
            pend_valid      <= 1'b0;
            cnt             <= '0;
            data_out_32x8   <= byte_of(pend_word, CNT_W'(0));
            selector_clk_4f <= '0;
          end else if (xfer) begin
            shift_word      <= data_in_32x8;
            cnt             <= '0;
            data_out_32x8   <= byte_of(data_in_32x8, CNT_W'(0));
            selector_clk_4f <= '0;
          end else begin
            state           <= IDLE;
            cnt             <= '0;
            data_out_32x8   <= '0;
            selector_clk_4f <= '0;
            valid_out_32x8  <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          valid_out_32x8 <= 1'b0;
          data_out_32x8  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_32x8_serial.sv
// Self-checking bench for mux_32x8_serial: both byte orders against a two-deep word queue model.
// Directed scenarios pin literal byte streams; a random phase exercises the handshake.
module tb_mux_32x8_serial;

  logic        clk_4f = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        valid_in = 1'b0;
  logic        ready_m, ready_l, valid_m, valid_l;
  logic [7:0]  data_m, data_l;
  logic [1:0]  sel_m, sel_l;

  always #5 clk_4f = ~clk_4f;

  mux_32x8_serial #(.MSB_FIRST(1'b1)) u_msb (
    .clk_4f(clk_4f), .reset(reset), .data_in_32x8(data_in), .valid_in_32x8(valid_in),
    .ready_out_32x8(ready_m), .data_out_32x8(data_m), .valid_out_32x8(valid_m),
    .selector_clk_4f(sel_m));

  mux_32x8_serial #(.MSB_FIRST(1'b0)) u_lsb (
    .clk_4f(clk_4f), .reset(reset), .data_in_32x8(data_in), .valid_in_32x8(valid_in),
    .ready_out_32x8(ready_l), .data_out_32x8(data_l), .valid_out_32x8(valid_l),
    .selector_clk_4f(sel_l));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: accepted words wait in a queue of at most two; the head is on the wire at byte pos.
  logic [31:0] mq[$];
  int          pos = -1;

  function automatic logic [7:0] pick(input logic [31:0] w, input int k, input bit msb);
    int sh;
    sh = msb ? 8 * (3 - k) : 8 * k;
    return 8'((w >> sh) & 32'hff);
  endfunction

  initial begin : model
    bit x;
    forever begin
      @(posedge clk_4f or posedge reset);
      if (reset) begin
        mq.delete();
        pos = -1;
      end else begin
        x = valid_in && (mq.size() < 2);
        if (pos >= 0) begin
          if (pos == 3) begin
            void'(mq.pop_front());
            pos = -1;
          end else begin
            pos++;
          end
        end
        if (x) mq.push_back(data_in);
        if (pos < 0 && mq.size() > 0) pos = 0;
      end
    end
  end

  // Compare process plus output logs for the directed scenarios.
  bit          cmp_en = 1'b0;
  int          cyc = 0;
  logic [7:0]  blog[$];
  int          clog[$];
  logic [31:0] rwords[$];

  initial begin : compare
    logic [31:0] asm_w;
    bit          ev;
    asm_w = 32'h0;
    forever begin
      @(negedge clk_4f);
      cyc++;
      if (cmp_en) begin
        ev = (pos >= 0);
        check("valid_msb", 32'(valid_m), 32'(ev));
        check("valid_lsb", 32'(valid_l), 32'(ev));
        check("data_msb", 32'(data_m), ev ? 32'(pick(mq[0], pos, 1'b1)) : 32'h0);
        check("data_lsb", 32'(data_l), ev ? 32'(pick(mq[0], pos, 1'b0)) : 32'h0);
        check("sel_msb", 32'(sel_m), ev ? 32'(pos) : 32'h0);
        check("sel_lsb", 32'(sel_l), ev ? 32'(pos) : 32'h0);
        check("ready_msb", 32'(ready_m), 32'(mq.size() < 2));
        check("ready_lsb", 32'(ready_l), 32'(mq.size() < 2));
      end
      if (valid_m) begin
        blog.push_back(data_m);
        clog.push_back(cyc);
      end
      if (valid_l) begin
        asm_w[8*int'(sel_l) +: 8] = data_l;
        if (sel_l == 2'd3) rwords.push_back(asm_w);
      end
    end
  end

  // Present a word and keep valid high until the accepting edge; returns 1ns after it.
  task automatic send(input logic [31:0] w);
    int   t;
    logic r;
    t = 0;
    data_in  = w;
    valid_in = 1'b1;
    do begin
      @(negedge clk_4f);
      r = ready_m;
      @(posedge clk_4f);
      #1;
      t++;
    end while (!r && t < 50);
    if (!r) check("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic clear_logs();
    blog.delete();
    clog.delete();
    rwords.delete();
  endtask

  task automatic expect_stream(input string nm, input logic [95:0] exp, input int n);
    check({nm, "_count"}, 32'(blog.size()), 32'(n));
    for (int i = 0; i < n && i < blog.size(); i++)
      check(nm, 32'(blog[i]), 32'(exp[8*(n-1-i) +: 8]));
    if (blog.size() == n)
      check({nm, "_contiguous"}, 32'(clog[n-1] - clog[0]), 32'(n - 1));
  endtask

  initial begin
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk_4f);
    #3 reset = 1'b0;

    // Idle after reset
    repeat (10) @(posedge clk_4f);
    #1;
    check("idle_no_bytes", 32'(blog.size()), 32'h0);

    // Single word: first byte one cycle after acceptance, then gap
    clear_logs();
    send(32'hA1B2C3D4);
    valid_in = 1'b0;
    @(negedge clk_4f);
    check("t2_first_byte", {21'h0, valid_m, sel_m, data_m}, {21'h0, 1'b1, 2'd0, 8'hA1});
    repeat (4) @(posedge clk_4f);
    @(negedge clk_4f);
    check("t2_fifth_cycle_idle", {23'h0, valid_m, data_m}, 32'h0);
    expect_stream("t2_bytes", {64'h0, 32'hA1B2C3D4}, 4);

    // Back-to-back words with skid register filling
    @(posedge clk_4f);
    #1;
    clear_logs();
    send(32'h01020304);
    send(32'h05060708);
    valid_in = 1'b0;
    @(negedge clk_4f);
    check("t3_ready_low", 32'(ready_m), 32'h0);
    repeat (2) @(posedge clk_4f);
    @(negedge clk_4f);
    check("t3_ready_still_low", 32'(ready_m), 32'h0);
    @(posedge clk_4f);
    @(negedge clk_4f);
    check("t3_ready_back", 32'(ready_m), 32'h1);
    repeat (6) @(posedge clk_4f);
    #1;
    expect_stream("t3_bytes", {32'h0, 64'h0102030405060708}, 8);

    // Three words under backpressure
    clear_logs();
    send(32'h11223344);
    send(32'h55667788);
    send(32'h99AABBCC);
    valid_in = 1'b0;
    repeat (14) @(posedge clk_4f);
    #1;
    expect_stream("t4_bytes", 96'h112233445566778899AABBCC, 12);

    // Asynchronous reset mid-word
    clear_logs();
    send(32'hDEADBEEF);
    valid_in = 1'b0;
    @(posedge clk_4f);
    #3 reset = 1'b1;
    #1;
    check("t5_async_clear", {21'h0, valid_m, sel_m, data_m}, 32'h0);
    check("t5_ready_after_reset", 32'(ready_m), 32'h1);
    #3 reset = 1'b0;
    clear_logs();
    repeat (10) @(posedge clk_4f);
    #1;
    check("t5_no_stale_bytes", 32'(blog.size()), 32'h0);

    // LSB-first instance reassembled by byte index
    clear_logs();
    send(32'h12345678);
    send(32'h9ABCDEF0);
    valid_in = 1'b0;
    repeat (10) @(posedge clk_4f);
    #1;
    check("t6_word_count", 32'(rwords.size()), 32'h2);
    if (rwords.size() == 2) begin
      check("t6_word0", rwords[0], 32'h12345678);
      check("t6_word1", rwords[1], 32'h9ABCDEF0);
    end

    // Random traffic; data held stable while stalled
    for (int i = 0; i < 400; i++) begin
      logic r;
      @(negedge clk_4f);
      r = ready_m;
      @(posedge clk_4f);
      #1;
      if (!(valid_in && !r)) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = $urandom;
      end
    end
    valid_in = 1'b0;
    repeat (10) @(posedge clk_4f);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
